// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity helper and legal
// parameter ranges used by both the receiver and the transmitter.
package uart_pkg;

    localparam int DATA_BITS_MIN  = 5;
    localparam int DATA_BITS_MAX  = 9;
    localparam int OVERSAMPLE_MIN = 8;
    localparam int OVERSAMPLE_MAX = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_t;

    typedef struct packed {
        logic parity_err;
        logic frame_err;
    } rx_status_t;

    // Parity bit a transmitter appends; narrower characters are zero-extended.
    function automatic logic parity_calc(input logic [DATA_BITS_MAX-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// Receiver-side bundle: serial line and oversample tick in, character and
// status out. master drives the line, slave is the receiver.
interface uart_rx_os_if #(
    parameter int DATA_BITS = 8
) ();
    logic                 rx_serial;
    logic                 os_tick;
    logic [DATA_BITS-1:0] data_out;
    logic                 rx_valid;
    logic                 parity_err;
    logic                 frame_err;
    logic                 busy;

    modport master (
        output rx_serial, os_tick,
        input  data_out, rx_valid, parity_err, frame_err, busy
    );

    modport slave (
        input  rx_serial, os_tick,
        output data_out, rx_valid, parity_err, frame_err, busy
    );
endinterface

// File: rtl/uart_rx_os_sync2.sv
// Two-flop synchroniser resetting to the idle-high level, with a registered
// falling-edge flag aligned to the synchronised output.
module uart_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic fall
);
    logic s1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1   <= 1'b1;
            q    <= 1'b1;
            fall <= 1'b0;
        end else begin
            s1   <= d;
            q    <= s1;
            // High in the same cycle q first shows the new low level.
            fall <= q & ~s1;
        end
    end
endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: start qualified at mid-bit, every data, parity
// and stop bit sampled at its centre, result delivered on a one-cycle pulse.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input logic         clk,
    input logic         rst_n,
    uart_rx_os_if.slave bus
);
    localparam int TW = $clog2(OVERSAMPLE);

    if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
        $error("uart_rx_os: DATA_BITS out of range");
    end
    if (OVERSAMPLE < OVERSAMPLE_MIN || OVERSAMPLE > OVERSAMPLE_MAX ||
        (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_oversample
        $error("uart_rx_os: OVERSAMPLE must be a power of two in range");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_rx_os: STOP_BITS must be 1 or 2");
    end
    if (PARITY_EN != 0 && PARITY_EN != 1) begin : g_bad_parity_en
        $error("uart_rx_os: PARITY_EN must be 0 or 1");
    end

    logic rx_s;
    logic rx_fall;

    uart_sync2 u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (bus.rx_serial),
        .q    (rx_s),
        .fall (rx_fall)
    );

    rx_state_t            state, state_nxt;
    logic [TW-1:0]        tick_cnt, tick_cnt_nxt;
    logic [3:0]           bit_cnt, bit_cnt_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic                 ferr_acc, ferr_acc_nxt;
    logic                 perr, perr_nxt;
    logic                 load;

    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    rx_status_t           status_q;

    logic mid_tick;
    assign mid_tick = bus.os_tick && (tick_cnt == TW'(OVERSAMPLE - 1));

    always_comb begin
        state_nxt    = state;
        tick_cnt_nxt = tick_cnt;
        bit_cnt_nxt  = bit_cnt;
        shreg_nxt    = shreg;
        ferr_acc_nxt = ferr_acc;
        perr_nxt     = perr;
        load         = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (rx_fall) begin
                    tick_cnt_nxt = '0;
                    state_nxt    = ST_START;
                end
            end
            ST_START: begin
                if (bus.os_tick) begin
                    if (tick_cnt == TW'(OVERSAMPLE / 2 - 1)) begin
                        if (rx_s) begin
                            state_nxt = ST_IDLE;
                        end else begin
                            tick_cnt_nxt = '0;
                            bit_cnt_nxt  = '0;
                            ferr_acc_nxt = 1'b0;
                            perr_nxt     = 1'b0;
                            state_nxt    = ST_DATA;
                        end
                    end else begin
                        tick_cnt_nxt = tick_cnt + TW'(1);
                    end
                end
            end
            ST_DATA: begin
                // tick_cnt wraps from OVERSAMPLE-1 to 0 by its width.
                if (bus.os_tick) tick_cnt_nxt = tick_cnt + TW'(1);
                if (mid_tick) begin
                    shreg_nxt = {rx_s, shreg[DATA_BITS-1:1]};
                    if (bit_cnt == 4'(DATA_BITS - 1)) begin
                        bit_cnt_nxt = '0;
                        state_nxt   = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (bus.os_tick) tick_cnt_nxt = tick_cnt + TW'(1);
                if (mid_tick) begin
                    perr_nxt  = rx_s != parity_calc(DATA_BITS_MAX'(shreg), 1'(PARITY_ODD));
                    state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bus.os_tick) tick_cnt_nxt = tick_cnt + TW'(1);
                if (mid_tick) begin
                    if (bit_cnt == 4'(STOP_BITS - 1)) begin
                        load        = 1'b1;
                        bit_cnt_nxt = '0;
                        // A low final stop may be a break; wait for idle before re-arming.
                        state_nxt   = rx_s ? ST_IDLE : ST_WAIT_HIGH;
                    end else begin
                        bit_cnt_nxt  = bit_cnt + 4'd1;
                        ferr_acc_nxt = ferr_acc | ~rx_s;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                if (rx_s) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            ferr_acc <= 1'b0;
            perr     <= 1'b0;
        end else begin
            state    <= state_nxt;
            tick_cnt <= tick_cnt_nxt;
            bit_cnt  <= bit_cnt_nxt;
            shreg    <= shreg_nxt;
            ferr_acc <= ferr_acc_nxt;
            perr     <= perr_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q   <= '0;
            valid_q  <= 1'b0;
            status_q <= '0;
        end else begin
            valid_q <= load;
            if (load) begin
                data_q              <= shreg;
                status_q.parity_err <= (PARITY_EN != 0) ? perr : 1'b0;
                status_q.frame_err  <= ferr_acc | ~rx_s;
            end
        end
    end

    assign bus.data_out   = data_q;
    assign bus.rx_valid   = valid_q;
    assign bus.parity_err = status_q.parity_err;
    assign bus.frame_err  = status_q.frame_err;
    assign bus.busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: frames are driven tick by tick, expected
// characters go into per-receiver queues checked by monitors on rx_valid.
module tb_uart_rx_os;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic os_tick = 1'b0;
    logic [1:0] div = 2'd0;
    logic line0 = 1'b1;
    logic line1 = 1'b1;
    int   tick_n = 0;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       busy;
        int         gap;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   last0 = 0;
    int   last1 = 0;

    uart_rx_os_if #(.DATA_BITS(8)) if0 ();
    uart_rx_os_if #(.DATA_BITS(8)) if1 ();

    assign if0.rx_serial = line0;
    assign if0.os_tick   = os_tick;
    assign if1.rx_serial = line1;
    assign if1.os_tick   = os_tick;

    uart_rx_os #(
        .DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)
    ) dut0 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (if0)
    );

    uart_rx_os #(
        .DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)
    ) dut1 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (if1)
    );

    always #5 clk = ~clk;

    // One tick every 4 clk cycles.
    always @(posedge clk) begin
        div     <= div + 2'd1;
        os_tick <= (div == 2'd3);
        if (os_tick) tick_n <= tick_n + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic compare(input string tag, input exp_t e, input logic [7:0] d,
                           input logic pe, input logic fe, input logic bz, input int gap);
        chk({tag, "_data"}, 32'(d), 32'(e.data));
        chk({tag, "_parity_err"}, 32'(pe), 32'(e.perr));
        chk({tag, "_frame_err"}, 32'(fe), 32'(e.ferr));
        chk({tag, "_busy"}, 32'(bz), 32'(e.busy));
        if (e.gap != 0) chk({tag, "_gap_ticks"}, 32'(gap), 32'(e.gap));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (if0.rx_valid) begin
            if (q0.size() == 0) begin
                n_checks++;
                $display("FAIL rx0_unexpected_valid: got data %0h expected no rx_valid", if0.data_out);
            end else begin
                e = q0.pop_front();
                compare("rx0", e, if0.data_out, if0.parity_err, if0.frame_err, if0.busy, tick_n - last0);
            end
            last0 = tick_n;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (if1.rx_valid) begin
            if (q1.size() == 0) begin
                n_checks++;
                $display("FAIL rx1_unexpected_valid: got data %0h expected no rx_valid", if1.data_out);
            end else begin
                e = q1.pop_front();
                compare("rx1", e, if1.data_out, if1.parity_err, if1.frame_err, if1.busy, tick_n - last1);
            end
            last1 = tick_n;
        end
    end

    // Returns just after the n-th clk edge at which the DUT sees os_tick high.
    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!os_tick) @(posedge clk);
        end
        #1;
    endtask

    task automatic set_line(input int which, input logic v);
        if (which == 0) line0 = v;
        else line1 = v;
    endtask

    task automatic send_bit(input int which, input logic b);
        set_line(which, b);
        wait_ticks(16);
    endtask

    task automatic send_frame(input int which, input logic [7:0] d, input logic has_par,
                              input logic par, input logic stop);
        send_bit(which, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(which, d[i]);
        if (has_par) send_bit(which, par);
        send_bit(which, stop);
    endtask

    function automatic exp_t mk(input logic [7:0] d, input logic pe, input logic fe,
                                input logic bz, input int gap);
        exp_t e;
        e.data = d; e.perr = pe; e.ferr = fe; e.busy = bz; e.gap = gap;
        return e;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] fb;
        fb = 8'hF0;

        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_data_out", 32'(if0.data_out), 32'h0);
        chk("reset_rx_valid", 32'(if0.rx_valid), 32'h0);
        chk("reset_parity_err", 32'(if0.parity_err), 32'h0);
        chk("reset_frame_err", 32'(if0.frame_err), 32'h0);
        chk("reset_busy0", 32'(if0.busy), 32'h0);
        chk("reset_busy1", 32'(if1.busy), 32'h0);
        wait_ticks(4);

        // Single clean frame
        q0.push_back(mk(8'hA5, 1'b0, 1'b0, 1'b0, 0));
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
        wait_ticks(4);

        // Back-to-back, no idle gap: valids 160 ticks apart
        q0.push_back(mk(8'h3C, 1'b0, 1'b0, 1'b0, 0));
        q0.push_back(mk(8'hC3, 1'b0, 1'b0, 1'b0, 160));
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'hC3, 1'b0, 1'b0, 1'b1);
        wait_ticks(4);

        // Even parity on the second receiver: 0x07 has three ones
        q1.push_back(mk(8'h07, 1'b0, 1'b0, 1'b0, 0));
        send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
        q1.push_back(mk(8'h07, 1'b1, 1'b0, 1'b0, 0));
        send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
        wait_ticks(4);

        // 4-tick low glitch: start rejected on the 8th tick
        line0 = 1'b0;
        wait_ticks(2);
        chk("glitch_busy_in_start", 32'(if0.busy), 32'h1);
        wait_ticks(2);
        line0 = 1'b1;
        wait_ticks(3);
        chk("glitch_busy_tick7", 32'(if0.busy), 32'h1);
        wait_ticks(1);
        chk("glitch_idle_tick8", 32'(if0.busy), 32'h0);
        wait_ticks(8);

        // Stop bit low, line held low 40 ticks, then recovery
        q0.push_back(mk(8'hF0, 1'b0, 1'b1, 1'b1, 0));
        send_bit(0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(0, fb[i]);
        line0 = 1'b0;
        wait_ticks(40);
        chk("break_wait_high_busy", 32'(if0.busy), 32'h1);
        line0 = 1'b1;
        wait_ticks(4);
        chk("break_released_idle", 32'(if0.busy), 32'h0);
        q0.push_back(mk(8'h55, 1'b0, 1'b0, 1'b0, 0));
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
        wait_ticks(4);

        // Reset in the middle of 0xFF's data bits
        send_bit(0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(0, 1'b1);
        wait_ticks(5);
        chk("pre_reset_busy", 32'(if0.busy), 32'h1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midreset_data_out", 32'(if0.data_out), 32'h0);
        chk("midreset_rx_valid", 32'(if0.rx_valid), 32'h0);
        chk("midreset_frame_err", 32'(if0.frame_err), 32'h0);
        chk("midreset_parity_err", 32'(if0.parity_err), 32'h0);
        chk("midreset_busy", 32'(if0.busy), 32'h0);
        rst_n = 1'b1;
        wait_ticks(20);
        chk("postreset_idle", 32'(if0.busy), 32'h0);
        q0.push_back(mk(8'h81, 1'b0, 1'b0, 1'b0, 0));
        send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1);
        wait_ticks(8);

        chk("rx0_all_delivered", 32'(q0.size()), 32'h0);
        chk("rx1_all_delivered", 32'(q1.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
